// File: rtl/execute_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the RV32 execute stage, bundled as one bus.
// The pipeline side drives the E signals (master); the execute stage drives the M signals (slave).
interface execute_stage_if #(
  parameter int XLEN = 32
);
  logic [3:0]      alu_controlE;
  logic            alu_srcE;
  logic            reg_writeE;
  logic            mem_writeE;
  logic [1:0]      result_srcE;
  logic            branchE;
  logic            jumpE;
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [XLEN-1:0] ImmExtE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PC_plus4E;
  logic [4:0]      RdE;
  logic [1:0]      forward_AE;
  logic [1:0]      forward_BE;
  logic [XLEN-1:0] resultW;

  logic [XLEN-1:0] alu_resultM;
  logic [XLEN-1:0] write_dataM;
  logic [4:0]      RdM;
  logic [XLEN-1:0] PC_plus4M;
  logic            reg_writeM;
  logic            mem_writeM;
  logic [1:0]      result_srcM;
  logic            PC_srcE;
  logic [XLEN-1:0] PC_targetE;
  logic            stallE;

  modport master (
    output alu_controlE, alu_srcE, reg_writeE, mem_writeE, result_srcE,
           branchE, jumpE, RD1E, RD2E, ImmExtE, PCE, PC_plus4E, RdE,
           forward_AE, forward_BE, resultW,
    input  alu_resultM, write_dataM, RdM, PC_plus4M, reg_writeM, mem_writeM,
           result_srcM, PC_srcE, PC_targetE, stallE
  );

  modport slave (
    input  alu_controlE, alu_srcE, reg_writeE, mem_writeE, result_srcE,
           branchE, jumpE, RD1E, RD2E, ImmExtE, PCE, PC_plus4E, RdE,
           forward_AE, forward_BE, resultW,
    output alu_resultM, write_dataM, RdM, PC_plus4M, reg_writeM, mem_writeM,
           result_srcM, PC_srcE, PC_targetE, stallE
  );
endinterface

// File: rtl/execute_stage.sv
// RV32 execute stage: operand forwarding, ALU, branch resolution, iterative
// shift-add multiplier (stalls the front end) and the EX/MEM pipeline register.
module execute_stage #(
  parameter int XLEN       = 32,
  parameter bit MUL_ENABLE = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  execute_stage_if.slave bus
);
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_reg;
  logic [4:0]      count_reg;
  logic [XLEN-1:0] mcand_reg;
  logic [XLEN-1:0] mplier_reg;
  logic [XLEN-1:0] acc_reg;

  logic [XLEN-1:0] alu_result_m_reg, alu_result_m_next;
  logic [XLEN-1:0] write_data_m_reg, write_data_m_next;
  logic [XLEN-1:0] pc_plus4_m_reg,   pc_plus4_m_next;
  logic [4:0]      rd_m_reg,         rd_m_next;
  logic            reg_write_m_reg,  reg_write_m_next;
  logic            mem_write_m_reg,  mem_write_m_next;
  logic [1:0]      result_src_m_reg, result_src_m_next;

  logic [1:0]      fwd_sel  [2];
  logic [XLEN-1:0] fwd_base [2];
  logic [XLEN-1:0] fwd_val  [2];

  logic [XLEN-1:0] src_a, b_pre, src_b;
  logic [XLEN-1:0] alu_result;
  logic [4:0]      shamt;
  logic            zero;
  logic            is_mul_op;
  logic            mul_start;
  logic            ex_valid;

  assign fwd_sel[0]  = bus.forward_AE;
  assign fwd_sel[1]  = bus.forward_BE;
  assign fwd_base[0] = bus.RD1E;
  assign fwd_base[1] = bus.RD2E;

  // Code 11 is unused by the hazard unit and falls back to the register file value.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_val[gi] = (fwd_sel[gi] == 2'b01) ? bus.resultW :
                           (fwd_sel[gi] == 2'b10) ? alu_result_m_reg :
                                                    fwd_base[gi];
    end
  endgenerate

  assign src_a = fwd_val[0];
  assign b_pre = fwd_val[1];
  assign src_b = bus.alu_srcE ? bus.ImmExtE : b_pre;
  assign shamt = src_b[4:0];

  // The multiply result never appears here; it arrives through acc_reg in DONE.
  always_comb begin
    alu_result = '0;
    case (bus.alu_controlE)
      OP_ADD:  alu_result = src_a + src_b;
      OP_SUB:  alu_result = src_a - src_b;
      OP_AND:  alu_result = src_a & src_b;
      OP_OR:   alu_result = src_a | src_b;
      OP_XOR:  alu_result = src_a ^ src_b;
      OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
      OP_SLL:  alu_result = src_a << shamt;
      OP_SRL:  alu_result = src_a >> shamt;
      OP_SRA:  alu_result = $unsigned($signed(src_a) >>> shamt);
      default: alu_result = '0;
    endcase
  end

  assign zero      = (alu_result == '0);
  assign is_mul_op = MUL_ENABLE && (bus.alu_controlE == OP_MUL);
  assign mul_start = (state_reg == IDLE) && is_mul_op;
  assign ex_valid  = ((state_reg == IDLE) && !mul_start) || (state_reg == DONE);

  assign bus.stallE     = mul_start || (state_reg == BUSY);
  assign bus.PC_srcE    = (state_reg == IDLE) && (bus.jumpE || (bus.branchE && zero));
  assign bus.PC_targetE = bus.PCE + bus.ImmExtE;

  // EX/MEM loads a bubble unless an instruction actually completes this cycle.
  always_comb begin
    alu_result_m_next = '0;
    write_data_m_next = '0;
    pc_plus4_m_next   = '0;
    rd_m_next         = '0;
    reg_write_m_next  = 1'b0;
    mem_write_m_next  = 1'b0;
    result_src_m_next = 2'b00;
    if (ex_valid) begin
      alu_result_m_next = (state_reg == DONE) ? acc_reg : alu_result;
      write_data_m_next = b_pre;
      pc_plus4_m_next   = bus.PC_plus4E;
      rd_m_next         = bus.RdE;
      reg_write_m_next  = bus.reg_writeE;
      mem_write_m_next  = bus.mem_writeE;
      result_src_m_next = bus.result_srcE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mul_start) begin
            mcand_reg  <= src_a;
            mplier_reg <= src_b;
            acc_reg    <= '0;
            count_reg  <= '0;
            state_reg  <= BUSY;
          end
        end
        BUSY: begin
          if (mplier_reg[0]) begin
            acc_reg <= acc_reg + mcand_reg;
          end
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          count_reg  <= count_reg + 5'd1;
          if (count_reg == 5'd31) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          // Returning to IDLE without looking at the op keeps the held mul from restarting.
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_m_reg <= '0;
      write_data_m_reg <= '0;
      pc_plus4_m_reg   <= '0;
      rd_m_reg         <= '0;
      reg_write_m_reg  <= 1'b0;
      mem_write_m_reg  <= 1'b0;
      result_src_m_reg <= 2'b00;
    end else begin
      alu_result_m_reg <= alu_result_m_next;
      write_data_m_reg <= write_data_m_next;
      pc_plus4_m_reg   <= pc_plus4_m_next;
      rd_m_reg         <= rd_m_next;
      reg_write_m_reg  <= reg_write_m_next;
      mem_write_m_reg  <= mem_write_m_next;
      result_src_m_reg <= result_src_m_next;
    end
  end

  assign bus.alu_resultM = alu_result_m_reg;
  assign bus.write_dataM = write_data_m_reg;
  assign bus.PC_plus4M   = pc_plus4_m_reg;
  assign bus.RdM         = rd_m_reg;
  assign bus.reg_writeM  = reg_write_m_reg;
  assign bus.mem_writeM  = mem_write_m_reg;
  assign bus.result_srcM = result_src_m_reg;

endmodule

// File: tb/tb_execute_stage.sv
// Directed plus randomized checks of execute_stage against an arithmetic
// reference model of the ALU, forwarding, branch and multiply rules.
module tb_execute_stage;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [31:0] m_alu;

  execute_stage_if #(.XLEN(32)) ex_if ();

  execute_stage #(.XLEN(32), .MUL_ENABLE(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ex_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_if.alu_controlE = 4'd0; ex_if.alu_srcE = 1'b0; ex_if.reg_writeE = 1'b0;
    ex_if.mem_writeE = 1'b0; ex_if.result_srcE = 2'b00; ex_if.branchE = 1'b0;
    ex_if.jumpE = 1'b0; ex_if.RD1E = '0; ex_if.RD2E = '0; ex_if.ImmExtE = '0;
    ex_if.PCE = '0; ex_if.PC_plus4E = '0; ex_if.RdE = '0; ex_if.forward_AE = 2'b00;
    ex_if.forward_BE = 2'b00; ex_if.resultW = '0;
  endtask

  // Reference ALU written from the op table, not from the RTL structure.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ones;
    logic [31:0] r;
    int s;
    ones = 32'hFFFF_FFFF;
    s = int'(b[4:0]);
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a + (~b + 32'd1);
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      4'd6:  r = {31'd0, a < b};
      4'd7:  r = a << s;
      4'd8:  r = a >> s;
      4'd9:  r = (a >> s) | (a[31] ? ~(ones >> s) : 32'd0);
      4'd10: r = a * b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] base);
    if (sel == 2'b01) return ex_if.resultW;
    if (sel == 2'b10) return m_alu;
    return base;
  endfunction

  task automatic check_bubble(input string tag);
    check({tag, "_alu"}, ex_if.alu_resultM, 32'd0);
    check({tag, "_wd"},  ex_if.write_dataM, 32'd0);
    check({tag, "_rd"},  ex_if.RdM, 32'd0);
    check({tag, "_pc4"}, ex_if.PC_plus4M, 32'd0);
    check({tag, "_rw"},  ex_if.reg_writeM, 32'd0);
    check({tag, "_mw"},  ex_if.mem_writeM, 32'd0);
    check({tag, "_rs"},  ex_if.result_srcM, 32'd0);
  endtask

  // One non-multiply instruction: check combinational outputs, clock it, check EX/MEM.
  task automatic exec(input string tag);
    logic [31:0] a, bp, b, r;
    logic exp_src;
    a  = ref_fwd(ex_if.forward_AE, ex_if.RD1E);
    bp = ref_fwd(ex_if.forward_BE, ex_if.RD2E);
    b  = ex_if.alu_srcE ? ex_if.ImmExtE : bp;
    r  = ref_alu(ex_if.alu_controlE, a, b);
    exp_src = ex_if.jumpE || (ex_if.branchE && (r == 32'd0));
    #1;
    check({tag, "_pcsrc"}, ex_if.PC_srcE, exp_src);
    check({tag, "_target"}, ex_if.PC_targetE, ex_if.PCE + ex_if.ImmExtE);
    check({tag, "_stall"}, ex_if.stallE, 32'd0);
    step();
    check({tag, "_alu"}, ex_if.alu_resultM, r);
    check({tag, "_wd"},  ex_if.write_dataM, bp);
    check({tag, "_rd"},  ex_if.RdM, ex_if.RdE);
    check({tag, "_rw"},  ex_if.reg_writeM, ex_if.reg_writeE);
    check({tag, "_mw"},  ex_if.mem_writeM, ex_if.mem_writeE);
    check({tag, "_rs"},  ex_if.result_srcM, ex_if.result_srcE);
    check({tag, "_pc4"}, ex_if.PC_plus4M, ex_if.PC_plus4E);
    $display("txn %s op=%0d result=%h", tag, ex_if.alu_controlE, ex_if.alu_resultM);
    m_alu = r;
  endtask

  // Multiply with A forwarded from resultW; resultW and jumpE are disturbed mid-run.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int cyc;
    logic [31:0] prod;
    prod = a * b;
    clear_inputs();
    ex_if.alu_controlE = 4'b1010; ex_if.forward_AE = 2'b01; ex_if.resultW = a;
    ex_if.RD1E = 32'h5A5A_5A5A; ex_if.RD2E = b; ex_if.RdE = rd; ex_if.reg_writeE = 1'b1;
    ex_if.PC_plus4E = 32'h0000_0404;
    #1;
    check({tag, "_stall_start"}, ex_if.stallE, 32'd1);
    cyc = 0;
    while (ex_if.stallE === 1'b1 && cyc < 100) begin
      step();
      cyc++;
      if (ex_if.stallE === 1'b1) begin
        check({tag, "_bub_alu"}, ex_if.alu_resultM, 32'd0);
        check({tag, "_bub_rw"},  ex_if.reg_writeM, 32'd0);
        check({tag, "_bub_rd"},  ex_if.RdM, 32'd0);
      end
      if (cyc == 5) begin
        ex_if.jumpE = 1'b1;
        ex_if.resultW = ~a;
        #1;
        check({tag, "_pcsrc_busy"}, ex_if.PC_srcE, 32'd0);
        ex_if.jumpE = 1'b0;
      end
    end
    check({tag, "_stall_cycles"}, cyc, 32'd33);
    check({tag, "_done_bubble"}, ex_if.reg_writeM, 32'd0);
    step();
    check({tag, "_product"}, ex_if.alu_resultM, prod);
    check({tag, "_rd"}, ex_if.RdM, rd);
    check({tag, "_rw"}, ex_if.reg_writeM, 32'd1);
    check({tag, "_pc4"}, ex_if.PC_plus4M, 32'h0000_0404);
    $display("txn %s a=%h b=%h product=%h stall_cycles=%0d", tag, a, b, ex_if.alu_resultM, cyc);
    m_alu = prod;
    clear_inputs();
    #1;
    check({tag, "_no_restart"}, ex_if.stallE, 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_alu = '0;
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
    check_bubble("reset");
    check("reset_stall", ex_if.stallE, 32'd0);

    // add with immediate
    ex_if.alu_controlE = 4'd0; ex_if.RD1E = 32'd5; ex_if.ImmExtE = 32'd7; ex_if.alu_srcE = 1'b1;
    ex_if.RdE = 5'd3; ex_if.reg_writeE = 1'b1; ex_if.PC_plus4E = 32'h10;
    exec("add_imm");
    check("add_imm_12", ex_if.alu_resultM, 32'd12);

    // forward A from EX/MEM, then B from writeback
    clear_inputs();
    ex_if.RD1E = 32'h10; ex_if.alu_srcE = 1'b1; ex_if.RdE = 5'd1; ex_if.reg_writeE = 1'b1;
    exec("seed_0x10");
    clear_inputs();
    ex_if.alu_controlE = 4'd1; ex_if.forward_AE = 2'b10; ex_if.RD1E = 32'hDEAD; ex_if.RD2E = 32'd1;
    exec("fwdA_sub");
    check("fwdA_sub_0xF", ex_if.alu_resultM, 32'hF);
    clear_inputs();
    ex_if.forward_BE = 2'b01; ex_if.resultW = 32'hAA; ex_if.RD2E = 32'h55; ex_if.mem_writeE = 1'b1;
    exec("fwdB_store");
    check("fwdB_store_0xAA", ex_if.write_dataM, 32'hAA);

    // beq taken / not taken
    clear_inputs();
    ex_if.alu_controlE = 4'd1; ex_if.branchE = 1'b1; ex_if.RD1E = 32'd9; ex_if.RD2E = 32'd9;
    ex_if.PCE = 32'h100; ex_if.ImmExtE = 32'hFFFF_FFF8;
    #1;
    check("beq_taken", ex_if.PC_srcE, 32'd1);
    check("beq_target", ex_if.PC_targetE, 32'hF8);
    ex_if.RD2E = 32'd8;
    #1;
    check("beq_not_taken", ex_if.PC_srcE, 32'd0);
    exec("beq_nt");

    // boundary ALU cases
    clear_inputs();
    ex_if.alu_controlE = 4'd9; ex_if.RD1E = 32'h8000_0000; ex_if.ImmExtE = 32'd4; ex_if.alu_srcE = 1'b1;
    exec("sra");
    check("sra_F8000000", ex_if.alu_resultM, 32'hF800_0000);
    clear_inputs();
    ex_if.alu_controlE = 4'd6; ex_if.RD1E = 32'd1; ex_if.RD2E = 32'hFFFF_FFFF;
    exec("sltu");
    check("sltu_1", ex_if.alu_resultM, 32'd1);

    // multiplies
    run_mul("mul_7x6", 32'd7, 32'd6, 5'd4);
    check("mul_7x6_42", ex_if.alu_resultM, 32'd42);
    run_mul("mul_neg1x2", 32'hFFFF_FFFF, 32'd2, 5'd9);
    check("mul_neg1x2_FFFFFFFE", ex_if.alu_resultM, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      run_mul("mul_rand", $urandom, $urandom, 5'($urandom_range(1, 31)));
    end

    // reset in the middle of a multiply
    clear_inputs();
    ex_if.alu_controlE = 4'b1010; ex_if.RD1E = 32'd3; ex_if.RD2E = 32'd3; ex_if.RdE = 5'd7;
    ex_if.reg_writeE = 1'b1;
    step();
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    clear_inputs();
    step();
    rst = 1'b0;
    check("rst_busy_stall", ex_if.stallE, 32'd0);
    check_bubble("rst_busy");
    m_alu = '0;
    ex_if.RD1E = 32'd3; ex_if.ImmExtE = 32'd4; ex_if.alu_srcE = 1'b1; ex_if.RdE = 5'd2;
    ex_if.reg_writeE = 1'b1;
    exec("post_rst_add");
    check("post_rst_add_7", ex_if.alu_resultM, 32'd7);

    // randomized non-multiply instructions
    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op == 4'b1010) op = 4'd0;
      ex_if.alu_controlE = op;
      ex_if.alu_srcE = 1'($urandom);
      ex_if.reg_writeE = 1'($urandom);
      ex_if.mem_writeE = 1'($urandom);
      ex_if.result_srcE = 2'($urandom_range(0, 2));
      ex_if.branchE = 1'($urandom);
      ex_if.jumpE = ($urandom_range(0, 7) == 0);
      ex_if.RD1E = $urandom;
      ex_if.RD2E = ($urandom_range(0, 3) == 0) ? ex_if.RD1E : $urandom;
      ex_if.ImmExtE = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      ex_if.PCE = $urandom;
      ex_if.PC_plus4E = ex_if.PCE + 32'd4;
      ex_if.RdE = 5'($urandom);
      ex_if.forward_AE = 2'($urandom);
      ex_if.forward_BE = 2'($urandom);
      ex_if.resultW = $urandom;
      exec("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage RV32 pipeline.
- Resolves operand forwarding, runs the ALU, and resolves branch/jump targets.
- Contains an iterative shift-add multiplier that stalls the front end while it runs.
- Registers its results into the EX/MEM pipeline register, which drives the memory/writeback stage directly downstream.

Parameters:
XLEN, 32, datapath width (only 32 supported).
MUL_ENABLE, 1, 1 = multiplier present; 0 = op 4'b1010 produces 0 with no stall.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
alu_controlE  in  4  ALU op select
alu_srcE  in  1  0 = operand B from RD2E, 1 = from ImmExtE
reg_writeE  in  1  register write enable
mem_writeE  in  1  store enable
result_srcE  in  2  writeback select (00 ALU, 01 load, 10 PC+4)
branchE  in  1  conditional branch (beq)
jumpE  in  1  unconditional jump
RD1E  in  32  register operand 1
RD2E  in  32  register operand 2
ImmExtE  in  32  sign-extended immediate
PCE  in  32  instruction PC
PC_plus4E  in  32  PC+4
RdE  in  5  destination register
forward_AE  in  2  A select: 00 RD1E, 01 resultW, 10 alu_resultM
forward_BE  in  2  B-pre select, same encoding, base RD2E
resultW  in  32  writeback-stage result
alu_resultM  out  32  EX/MEM ALU/multiply result
write_dataM  out  32  forwarded B-pre, store data
RdM  out  5  EX/MEM destination register
PC_plus4M  out  32  EX/MEM PC+4
reg_writeM  out  1  EX/MEM write enable
mem_writeM  out  1  EX/MEM store enable
result_srcM  out  2  EX/MEM writeback select
PC_srcE  out  1  redirect fetch (combinational)
PC_targetE  out  32  PCE + ImmExtE (combinational)
stallE  out  1  freeze PC, IF/ID, ID/EX (combinational)

Behaviour:
- Reset: all M outputs 0, FSM = IDLE, counter 0. With FSM in IDLE, stallE follows only the current inputs (see MUL below); no multiply is in progress.
- Forward code 2'b11 selects RD1E/RD2E.
- Operand B = alu_srcE ? ImmExtE : B-pre.
- ALU ops:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
  - 0101 slt (signed), 0110 sltu.
  - 0111 sll, 1000 srl, 1001 sra; shift amount = B[4:0].
  - 1010 mul, low 32 bits.
  - Other codes yield 0.
- Add/sub wrap mod 2^32.
- zero = (ALU result == 0).
- PC_srcE = jumpE | (branchE & zero). Forced 0 while the FSM is not IDLE.
- Non-mul op: EX/MEM loads ALU result, B-pre and control on every edge. Latency 1 cycle.
- MUL FSM states IDLE, BUSY, DONE:
  - IDLE with op 1010: stallE=1; operands A and B latched; EX/MEM loads a bubble; go to BUSY with count=0.
  - BUSY: each cycle, if multiplier bit0 is set, acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++. stallE=1; EX/MEM loads a bubble. After count reaches 31 (32 iterations), go to DONE.
  - DONE: stallE=0; EX/MEM captures acc plus the held control; go to IDLE. The held op 1010 does not restart the multiplier.
  - Total 34 cycles in EX.
- Bubble: reg_writeM=0, mem_writeM=0, RdM=0, result_srcM=00, all data outputs 0.
- Operands are latched at start, so changes on resultW/alu_resultM during the stall do not affect the product.
- Reset asserted in any state: next edge gives IDLE, bubble outputs, stallE=0, and the partial product is discarded.
- ID/EX holds its inputs stable while stallE=1; the block does not check this.

Test Plan:
- RD1E=5, ImmExtE=7, alu_srcE=1, op add, RdE=3, reg_writeE=1 -> after 1 edge: alu_resultM=12, RdM=3, reg_writeM=1.
- forward_AE=10 with prior alu_resultM=0x10, RD2E=1, op sub -> alu_resultM=0xF. Then forward_BE=01, resultW=0xAA, mem_writeE=1 -> write_dataM=0xAA.
- branchE=1, RD1E=RD2E=9, op sub, PCE=0x100, ImmExtE=-8 -> PC_srcE=1, PC_targetE=0xF8. With RD2E=8 -> PC_srcE=0.
- mul 7*6, RdE=4 -> stallE high for exactly 33 cycles, bubbles in EX/MEM meanwhile. On the 34th edge: alu_resultM=42, RdM=4. No restart afterward.
- mul 0xFFFFFFFF*2 -> 0xFFFFFFFE. sra of 0x80000000 by 4 -> 0xF8000000. sltu 1 vs 0xFFFFFFFF -> 1.
- rst asserted for 1 cycle at BUSY count=10 -> next cycle: stallE=0, all M outputs 0. A subsequent add executes normally.
